// File: rtl/program_memory_loader_pkg.sv
// Shared widths and state encoding for the program memory loader
// and the CPU top that consumes its fetch port.
package program_memory_loader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

endpackage

// File: rtl/program_memory_loader_rise_detect.sv
// Rising-edge detector for a level input such as a board button.
// Reusable for any synchronous single-clock button.
module program_memory_loader_rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) level_q <= 1'b0;
    else       level_q <= level_i;
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/program_memory_loader.sv
// Instruction-side responder: byte-wise program load from switches,
// combinational fetch, and CPU hold until the program is started.
module program_memory_loader
  import program_memory_loader_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter int DATA_W_P = DATA_W,
  parameter int DEPTH    = 2 ** ADDR_W_P
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [ADDR_W_P-1:0] read_address,
  output logic [DATA_W_P-1:0] instruction,
  input  logic                load_mode,
  input  logic [DATA_W_P-1:0] load_data,
  input  logic                load_strobe,
  output logic                cpu_hold,
  output logic [ADDR_W_P:0]   load_count,
  output logic                mem_full,
  output logic [1:0]          state
);

  localparam logic [ADDR_W_P:0] FULL_CNT = (ADDR_W_P+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W_P:0]   cnt_q, cnt_d;
  logic                we;
  logic                strobe_rise;
  logic [DATA_W_P-1:0] mem [0:DEPTH-1];

  program_memory_loader_rise_detect u_rise (
    .clk_i   (clk_in),
    .rst_i   (reset),
    .level_i (load_strobe),
    .rise_o  (strobe_rise)
  );

  assign mem_full = (cnt_q == FULL_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_mode) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else if (strobe_rise) begin
          state_d = ST_RUN;
        end
      end
      // A mode drop outranks a simultaneous strobe edge.
      ST_LOAD: begin
        if (!load_mode) begin
          state_d = ST_IDLE;
        end else if (strobe_rise && !mem_full) begin
          we    = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (load_mode) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Contents deliberately survive reset; load_count gates visibility.
  always_ff @(posedge clk_in) begin
    if (we) mem[cnt_q[ADDR_W_P-1:0]] <= load_data;
  end

  assign cpu_hold   = (state_q != ST_RUN);
  assign load_count = cnt_q;
  assign state      = state_q;

  always_comb begin
    instruction = '0;
    if (!cpu_hold && ({1'b0, read_address} < cnt_q))
      instruction = mem[read_address];
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench: transaction-level model plus literal spot checks.
module tb_program_memory_loader;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] read_address = 8'h00;
  logic [7:0] instruction;
  logic       load_mode = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_strobe = 1'b0;
  logic       cpu_hold;
  logic [8:0] load_count;
  logic       mem_full;
  logic [1:0] state;

  program_memory_loader dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .read_address (read_address),
    .instruction  (instruction),
    .load_mode    (load_mode),
    .load_data    (load_data),
    .load_strobe  (load_strobe),
    .cpu_hold     (cpu_hold),
    .load_count   (load_count),
    .mem_full     (mem_full),
    .state        (state)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  int         m_state = 0;
  int         m_cnt = 0;
  logic [7:0] m_mem [256];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_instr(logic [7:0] a);
    if (m_state != 2 || int'(a) >= m_cnt) return 0;
    return int'(m_mem[a]);
  endfunction

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("state", int'(state), m_state);
      chk("cpu_hold", int'(cpu_hold), int'(m_state != 2));
      chk("load_count", int'(load_count), m_cnt);
      chk("mem_full", int'(mem_full), int'(m_cnt == 256));
      chk("instruction", int'(instruction), exp_instr(read_address));
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    load_strobe = 1'b0;
    repeat (n) begin
      step();
      m_state = 0;
      m_cnt = 0;
    end
    reset = 1'b0;
  endtask

  task automatic set_mode(bit v);
    load_mode = v;
    step();
    if (v && m_state != 1) begin
      m_state = 1;
      m_cnt = 0;
    end else if (!v && m_state == 1) begin
      m_state = 0;
    end
  endtask

  // Strobe high for hold cycles, then low; one rising edge only.
  task automatic strobe(logic [7:0] b, int hold);
    load_data = b;
    load_strobe = 1'b1;
    step();
    if (m_state == 1 && m_cnt < 256) begin
      m_mem[m_cnt] = b;
      m_cnt++;
    end else if (m_state == 0) begin
      m_state = 2;
    end
    repeat (hold - 1) step();
    load_strobe = 1'b0;
    step();
  endtask

  task automatic read_lit(logic [7:0] a, logic [7:0] exp, string name);
    read_address = a;
    #1;
    chk(name, int'(instruction), int'(exp));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset then idle
    do_reset(2);
    chk_en = 1'b1;
    chk("t1_state", int'(state), 0);
    chk("t1_hold", int'(cpu_hold), 1);
    chk("t1_count", int'(load_count), 0);
    read_lit(8'h00, 8'h00, "t1_rd00");
    read_lit(8'h80, 8'h00, "t1_rd80");
    read_lit(8'hFF, 8'h00, "t1_rdFF");

    // 2: load three bytes and run
    set_mode(1'b1);
    chk("t2_state_load", int'(state), 1);
    strobe(8'h41, 1);
    strobe(8'h82, 1);
    strobe(8'hC1, 1);
    chk("t2_count", int'(load_count), 3);
    set_mode(1'b0);
    strobe(8'h00, 1);
    chk("t2_state_run", int'(state), 2);
    chk("t2_hold", int'(cpu_hold), 0);
    read_lit(8'h00, 8'h41, "t2_rd0");
    read_lit(8'h01, 8'h82, "t2_rd1");
    read_lit(8'h02, 8'hC1, "t2_rd2");
    read_lit(8'h03, 8'h00, "t2_rd3");
    strobe(8'h00, 1);
    chk("t2_run_ignores_strobe", int'(state), 2);

    // 3: held strobe writes once
    set_mode(1'b1);
    chk("t3_hold_reasserted", int'(cpu_hold), 1);
    chk("t3_count_clear", int'(load_count), 0);
    strobe(8'h99, 10);
    chk("t3_count", int'(load_count), 1);

    // 5: collision, mode drop wins
    load_mode = 1'b0;
    load_data = 8'hAA;
    load_strobe = 1'b1;
    step();
    m_state = 0;
    load_strobe = 1'b0;
    step();
    chk("t5_state", int'(state), 0);
    chk("t5_count", int'(load_count), 1);

    // 4: fill all 256 bytes, then one extra strobe
    set_mode(1'b1);
    for (int i = 0; i < 256; i++) strobe(8'(i) ^ 8'h5A, 1);
    chk("t4_count", int'(load_count), 256);
    chk("t4_full", int'(mem_full), 1);
    strobe(8'hEE, 1);
    chk("t4_count_sat", int'(load_count), 256);
    set_mode(1'b0);
    strobe(8'h00, 1);
    read_lit(8'h00, 8'h5A, "t4_rd0");
    read_lit(8'h01, 8'h5B, "t4_rd1");
    read_lit(8'hFF, 8'hA5, "t4_rdFF");
    for (int a = 0; a < 256; a += 17) begin
      read_address = 8'(a);
      step();
    end

    // 6: reset mid-load hides stale bytes
    set_mode(1'b1);
    strobe(8'h11, 1);
    strobe(8'h22, 1);
    load_mode = 1'b0;
    do_reset(2);
    chk("t6_count_rst", int'(load_count), 0);
    strobe(8'h00, 1);
    chk("t6_run", int'(state), 2);
    read_lit(8'h00, 8'h00, "t6_rd0_stale");
    read_lit(8'h01, 8'h00, "t6_rd1_stale");
    read_lit(8'h80, 8'h00, "t6_rd80_stale");
    set_mode(1'b1);
    strobe(8'h55, 1);
    set_mode(1'b0);
    strobe(8'h00, 1);
    read_lit(8'h00, 8'h55, "t6_rd0");
    read_lit(8'h01, 8'h00, "t6_rd1");

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
